// File: rtl/fetch_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_ctrl_pkg
// Description : Shared fetch-stage definitions: packet geometry, sequencer
//               state encoding and the fetch-packet record handed to the
//               fetch queue.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_ctrl_pkg;

    localparam int FETCH_BYTES = 8;
    localparam int INST_W      = 32;
    localparam int XLEN        = 64;
    localparam int FETCH_WIDTH = (FETCH_BYTES * 8) / INST_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0]                    pc;
        logic [FETCH_WIDTH-1:0]             valids;
        logic [FETCH_WIDTH-1:0][INST_W-1:0] insts;
        logic                               bp_taken;
        logic                               bp_select;
        logic [XLEN-1:0]                    bp_target;
    } fetch_packet_t;

    // Base address of the fetch packet containing pc.
    function automatic logic [XLEN-1:0] packet_base(input logic [XLEN-1:0] pc);
        return pc & ~XLEN'(FETCH_BYTES - 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_pc_fifo.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pc_fifo
// Description : Small FIFO holding the fetch PC of every outstanding icache
//               request, so in-order responses can be tagged with their PC.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_pc_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_flush,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic             o_empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_full;
    logic             w_push;
    logic             w_pop;

    assign o_empty = (r_count == '0);
    assign w_full  = (r_count == CNT_W'(DEPTH));
    assign w_pop   = i_pop && !o_empty;
    assign w_push  = i_push && (!w_full || w_pop);
    assign o_head  = r_mem[r_rd_ptr];

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + 1'b1;
    endfunction

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= next_ptr(r_wr_ptr);
            if (w_pop)  r_rd_ptr <= next_ptr(r_rd_ptr);
            r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end

    // Storage; contents are only meaningful while counted as occupied.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_push_data;
    end

endmodule
`default_nettype wire

// File: rtl/fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fetch_ctrl
// Description : Fetch-stage sequencer. Issues packet-aligned icache requests
//               under a fetch-queue credit limit, turns in-order responses
//               into enqueue packets, follows predicted-taken branches and
//               backend redirects by discarding stale in-flight responses.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter logic [63:0] RESET_PC     = 64'h8000_0000,
    parameter int          QUEUE_DEPTH  = 4,
    parameter int          MAX_INFLIGHT = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              io_redirect_valid,
    input  logic [XLEN-1:0]   io_redirect_target,
    output logic              io_icache_req_valid,
    input  logic              io_icache_req_ready,
    output logic [XLEN-1:0]   io_icache_req_addr,
    input  logic              io_icache_resp_valid,
    input  logic [INST_W-1:0] io_icache_resp_insts_0,
    input  logic [INST_W-1:0] io_icache_resp_insts_1,
    input  logic              io_bp_taken,
    input  logic              io_bp_select,
    input  logic [XLEN-1:0]   io_bp_target,
    output logic              io_fq_enq_valid,
    output logic [XLEN-1:0]   io_fq_enq_pc,
    output logic              io_fq_enq_valids_0,
    output logic              io_fq_enq_valids_1,
    output logic [INST_W-1:0] io_fq_enq_insts_0,
    output logic [INST_W-1:0] io_fq_enq_insts_1,
    output logic              io_fq_enq_bp_taken,
    output logic              io_fq_enq_bp_select,
    output logic [XLEN-1:0]   io_fq_enq_bp_target,
    input  logic              io_fq_deq_fire,
    output logic              io_fq_flush
);

    localparam int OCC_W = $clog2(QUEUE_DEPTH + 1);
    localparam int INF_W = $clog2(MAX_INFLIGHT + 1);

    localparam logic [1:0] ST_IDLE  = IDLE;
    localparam logic [1:0] ST_FETCH = FETCH;
    localparam logic [1:0] ST_DRAIN = DRAIN;

    logic [1:0]       r_state;
    logic [XLEN-1:0]  r_fetch_pc;
    logic [OCC_W-1:0] r_occupancy;
    logic [INF_W-1:0] r_inflight;
    logic [INF_W-1:0] r_drop_cnt;

    logic [31:0]      w_used;
    logic             w_credit_ok;
    logic             w_req_valid;
    logic             w_req_fire;
    logic             w_enq;
    logic             w_taken;
    logic             w_deq;
    logic [INF_W-1:0] w_drop_next;
    logic [XLEN-1:0]  w_fetch_pc_next;
    logic [XLEN-1:0]  w_head_pc;
    logic             w_fifo_empty;
    fetch_packet_t    w_pkt;
    fetch_packet_t    w_pkt_out;

    // Credits: every queue slot is held either by a queued packet or by a
    // request whose response has not returned yet.
    assign w_used      = 32'(r_occupancy) + 32'(r_inflight);
    assign w_credit_ok = (w_used < 32'(QUEUE_DEPTH));

    assign w_req_valid = (r_state == ST_FETCH) && w_credit_ok &&
                         (r_inflight < INF_W'(MAX_INFLIGHT)) && !io_redirect_valid;
    assign w_req_fire  = w_req_valid && io_icache_req_ready;
    assign w_enq       = io_icache_resp_valid && (r_drop_cnt == '0) && !io_redirect_valid;
    assign w_taken     = w_enq && io_bp_taken;
    assign w_deq       = io_fq_deq_fire && (r_occupancy != '0);

    assign io_icache_req_valid = w_req_valid;
    assign io_icache_req_addr  = packet_base(r_fetch_pc);
    assign io_fq_flush         = io_redirect_valid;

    // Every response pops the PC FIFO, dropped or not, so tags stay aligned.
    fetch_pc_fifo #(
        .DEPTH (MAX_INFLIGHT),
        .WIDTH (XLEN)
    ) u_pc_fifo (
        .clk         (clock),
        .rst         (reset),
        .i_flush     (r_state == ST_IDLE),
        .i_push      (w_req_fire),
        .i_push_data (r_fetch_pc),
        .i_pop       (io_icache_resp_valid),
        .o_head      (w_head_pc),
        .o_empty     (w_fifo_empty)
    );

    // Assemble the enqueue packet; slot 0 is dead when fetch started mid-packet,
    // slot 1 is dead when the taken branch sits in slot 0.
    always_comb begin
        w_pkt           = '0;
        w_pkt.pc        = w_head_pc;
        w_pkt.valids[0] = ~w_head_pc[2];
        w_pkt.valids[1] = ~(io_bp_taken && !io_bp_select);
        w_pkt.insts[0]  = io_icache_resp_insts_0;
        w_pkt.insts[1]  = io_icache_resp_insts_1;
        w_pkt.bp_taken  = io_bp_taken;
        w_pkt.bp_select = io_bp_select;
        w_pkt.bp_target = io_bp_target;
        w_pkt_out       = w_enq ? w_pkt : '0;
    end

    assign io_fq_enq_valid     = w_enq;
    assign io_fq_enq_pc        = w_pkt_out.pc;
    assign io_fq_enq_valids_0  = w_pkt_out.valids[0];
    assign io_fq_enq_valids_1  = w_pkt_out.valids[1];
    assign io_fq_enq_insts_0   = w_pkt_out.insts[0];
    assign io_fq_enq_insts_1   = w_pkt_out.insts[1];
    assign io_fq_enq_bp_taken  = w_pkt_out.bp_taken;
    assign io_fq_enq_bp_select = w_pkt_out.bp_select;
    assign io_fq_enq_bp_target = w_pkt_out.bp_target;

    // Next fetch PC and number of stale responses still to be discarded.
    always_comb begin
        w_fetch_pc_next = r_fetch_pc;
        w_drop_next     = r_drop_cnt;
        if (io_redirect_valid) begin
            w_fetch_pc_next = io_redirect_target;
            w_drop_next     = r_inflight - INF_W'(io_icache_resp_valid);
        end else if (w_taken) begin
            // Everything younger than this packet, including a request
            // leaving this very cycle, is down the wrong path.
            w_fetch_pc_next = io_bp_target;
            w_drop_next     = r_inflight - INF_W'(1) + INF_W'(w_req_fire);
        end else begin
            if (w_req_fire) w_fetch_pc_next = packet_base(r_fetch_pc) + XLEN'(FETCH_BYTES);
            if (io_icache_resp_valid && (r_drop_cnt != '0)) w_drop_next = r_drop_cnt - INF_W'(1);
        end
    end

    // Sequencer state, counters and fetch PC.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_fetch_pc  <= RESET_PC;
            r_occupancy <= '0;
            r_inflight  <= '0;
            r_drop_cnt  <= '0;
        end else begin
            r_fetch_pc <= w_fetch_pc_next;
            r_drop_cnt <= w_drop_next;
            r_inflight <= r_inflight + INF_W'(w_req_fire) - INF_W'(io_icache_resp_valid);
            if (io_redirect_valid) r_occupancy <= '0;
            else                   r_occupancy <= r_occupancy + OCC_W'(w_enq) - OCC_W'(w_deq);
            if (r_state == ST_IDLE)       r_state <= ST_FETCH;
            else if (w_drop_next != '0)   r_state <= ST_DRAIN;
            else                          r_state <= ST_FETCH;
        end
    end

`ifndef SYNTHESIS
    // Protocol sanity: responses only for outstanding requests, queue never overfilled.
    always @(posedge clock) begin
        if (!reset && io_icache_resp_valid)
            assert (r_inflight != '0 && !w_fifo_empty)
                else $error("icache response with no request outstanding");
        if (!reset)
            assert (32'(r_occupancy) <= 32'(QUEUE_DEPTH))
                else $error("fetch queue occupancy above depth");
    end
`endif

endmodule
`default_nettype wire

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
Fetch-stage sequencer that sits between the PC/branch-predictor logic, the instruction cache and the fetch queue.
- Generates 8-byte-aligned fetch-packet addresses and issues them to the icache.
- Turns in-order icache responses into fetch-queue enqueue packets.
- Throttles issue with a credit count so the queue never overflows.
- On backend redirect: flushes the queue and discards stale in-flight responses.

Parameters:
RESET_PC, 64'h8000_0000, first fetch address after reset
QUEUE_DEPTH, 4, fetch queue entries (credit pool size)
MAX_INFLIGHT, 2, max outstanding icache requests

Ports:
clock  in  1  clock
reset  in  1  synchronous active-high reset
io_redirect_valid  in  1  backend redirect/flush
io_redirect_target  in  64  redirect PC
io_icache_req_valid  out  1  fetch request
io_icache_req_ready  in  1  icache accepts request
io_icache_req_addr  out  64  packet address, bits[2:0]=0
io_icache_resp_valid  in  1  in-order response
io_icache_resp_insts_0  in  32  instruction at addr
io_icache_resp_insts_1  in  32  instruction at addr+4
io_bp_taken  in  1  predictor: packet contains predicted-taken branch (sampled with response)
io_bp_select  in  1  slot of taken branch (0/1)
io_bp_target  in  64  predicted target
io_fq_enq_valid  out  1  enqueue to fetch queue
io_fq_enq_pc  out  64  fetch PC of packet
io_fq_enq_valids_0  out  1  slot0 valid
io_fq_enq_valids_1  out  1  slot1 valid
io_fq_enq_insts_0  out  32  slot0 instruction
io_fq_enq_insts_1  out  32  slot1 instruction
io_fq_enq_bp_taken  out  1  forwarded io_bp_taken
io_fq_enq_bp_select  out  1  forwarded io_bp_select
io_fq_enq_bp_target  out  64  forwarded io_bp_target
io_fq_deq_fire  in  1  queue dequeued an entry this cycle
io_fq_flush  out  1  flush to fetch queue

Behaviour:
- Reset:
  - fetch_pc = RESET_PC; state = IDLE.
  - inflight = occupancy = drop_cnt = 0.
  - All outputs 0 except io_icache_req_addr = RESET_PC with bits[2:0] cleared.
- Credits: credit = QUEUE_DEPTH - occupancy - inflight.
  - occupancy +1 on io_fq_enq_valid, -1 on io_fq_deq_fire; both in the same cycle leaves it unchanged.
  - inflight +1 on request fire, -1 on response; drop_cnt is decremented on its own, separately from inflight.
- FSM states: IDLE, FETCH, DRAIN.
  - IDLE lasts exactly one cycle after reset, then goes to FETCH.
  - FETCH issues requests.
  - DRAIN is entered on redirect when inflight > 0 (excluding a response arriving that cycle). It returns to FETCH when drop_cnt reaches 0.
- Request issue:
  - io_icache_req_valid = (state==FETCH) && credit>0 && inflight<MAX_INFLIGHT && !io_redirect_valid.
  - Address is {fetch_pc[63:3],3'b0}.
  - On fire: issued_pc = fetch_pc is queued into an internal PC FIFO of depth MAX_INFLIGHT; fetch_pc <= (fetch_pc & ~7) + 8.
  - valid must hold until ready; the address is stable while valid.
- Response (not dropped):
  - Enqueue is combinational, 0-cycle: io_fq_enq_valid = io_icache_resp_valid && drop_cnt==0 && !io_redirect_valid.
  - pc = PC FIFO head.
  - valids_0 = ~pc[2].
  - valids_1 = ~(io_bp_taken && io_bp_select==0).
- Predicted taken on an enqueued response:
  - fetch_pc <= io_bp_target.
  - drop_cnt <= inflight-1, counting requests issued after this packet.
  - Any request firing the same cycle is also dropped (drop_cnt +1).
  - Enter DRAIN if drop_cnt is nonzero.
- Dropped response: consumed, PC FIFO popped, drop_cnt decremented, no enqueue.
- Redirect (highest priority):
  - io_fq_flush=1 in the same cycle.
  - occupancy <= 0; fetch_pc <= io_redirect_target.
  - drop_cnt <= inflight minus any response arriving this cycle; that response is discarded.
  - No request issues that cycle.
  - Redirect during DRAIN reloads drop_cnt by the same rule.
- PC arithmetic wraps mod 2^64.
- Invariants:
  - occupancy ≤ QUEUE_DEPTH.
  - A response with inflight==0 is illegal; assert it.

Decomposition:
- Shared fetch package holds:
  - FETCH_BYTES=8 and the INST_W=32 constant.
  - The fetch_state enum {IDLE,FETCH,DRAIN}.
  - The fetch-packet struct (pc, valids, insts, bp fields), shared with the fetch queue.
- Sub-module fetch_pc_fifo: small PC FIFO of depth MAX_INFLIGHT with push/pop/flush.

Test Plan:
- Reset, ready=1, 1-cycle response, no deq:
  - Requests issue to 0x8000_0000, 0x8000_0008, …
  - Exactly 4 enqueues occur, then req_valid=0 while credit=0.
  - One io_fq_deq_fire then produces exactly one more request.
- Redirect to 0x8000_1004 with 2 requests in flight:
  - io_fq_flush pulses; both stale responses are dropped with no enqueue.
  - The next request has addr 0x8000_1000.
  - Its enqueue has valids_0=0, valids_1=1.
- Response for PC 0x8000_0000 with bp_taken=1, select=0, target 0x8000_0100, one younger request in flight:
  - Enqueue has valids_1=0.
  - The younger response is dropped; the next address is 0x8000_0100.
- icache req_ready held low 5 cycles:
  - req_valid and addr stay stable; no duplicate issue.
- Redirect in the same cycle as a response, and again during DRAIN:
  - The response is not enqueued; drop_cnt is recomputed.
  - FETCH resumes at the second target only.
- Reset asserted mid-DRAIN:
  - Next cycle all counters are 0, state is IDLE, and fetch resumes at RESET_PC.
